transposed_buffer_reader: RTL
=============================

Name: transposed_buffer_reader

Overview:
- Row-in/column-out transpose buffer for the interpolation datapath.
- Accepts an NxN block of signed samples one row per cycle, then returns the block one column per cycle with a valid/ready handshake.
- Sits between the horizontal filter stage, which writes rows, and the vertical filter stage, which reads columns.
- Storage is NxN single-sample registers with write enable and async clear; this block owns all addressing and sequencing for them.

Parameters:
- N, 8, block dimension; rows/columns per block, legal 2..16.
- DATA_W, 11, sample width, signed two's complement.

Ports:
- CLK  in  1  clock, rising edge.
- RST_ASYNC_N  in  1  asynchronous active-low reset.
- SYNC_CLR  in  1  synchronous abort of the current block.
- WR_VALID  in  1  WR_ROW holds a valid row.
- WR_READY  out  1  block accepts a row this cycle.
- WR_ROW  in  N*DATA_W  row samples; sample k (column k) at bits [k*DATA_W +: DATA_W].
- RD_VALID  out  1  RD_COL holds a valid column.
- RD_READY  in  1  consumer takes the column this cycle.
- RD_COL  out  N*DATA_W  column samples; sample r (row r) at bits [r*DATA_W +: DATA_W].
- RD_COL_IDX  out  $clog2(N)  index of the column currently on RD_COL.
- RD_LAST  out  1  high with RD_VALID when RD_COL_IDX == N-1.

Behaviour:
- Reset (RST_ASYNC_N low, async):
  - All storage = 0; state = FILL; row_cnt = 0; col_cnt = 0.
  - RD_VALID = 0; RD_LAST = 0; RD_COL_IDX = 0; RD_COL = 0; WR_READY = 1 once reset releases.
- States: FILL, DRAIN.
- FILL:
  - WR_READY = 1, RD_VALID = 0.
  - On a write handshake (WR_VALID & WR_READY), store WR_ROW into row row_cnt; row_cnt++.
  - On the handshake with row_cnt == N-1: row_cnt -> 0, state -> DRAIN.
- DRAIN:
  - WR_READY = 0; RD_VALID = 1.
  - RD_COL is driven combinationally from storage column col_cnt; RD_COL_IDX = col_cnt.
  - On a read handshake (RD_VALID & RD_READY): col_cnt++.
  - On the handshake with col_cnt == N-1: col_cnt -> 0, state -> FILL.
- Latency and throughput:
  - Last row written at edge t gives RD_VALID = 1 from cycle t+1, with column 0 presented.
  - Last column accepted at edge u gives WR_READY = 1 at cycle u+1.
  - Full-rate throughput = one block per 2N cycles.
- Backpressure:
  - RD_READY low holds RD_COL, RD_COL_IDX and RD_LAST stable indefinitely.
  - WR_VALID low in FILL leaves row_cnt unchanged; rows may arrive with gaps.
- Storage is never modified in DRAIN; WR_ROW is ignored while WR_READY = 0.
- SYNC_CLR:
  - On the next edge: state -> FILL, row_cnt = col_cnt = 0. Storage contents are untouched.
  - SYNC_CLR overrides any handshake in the same cycle; that row or column is discarded.
- Data passes through bit-exact; no arithmetic, no sign extension, no saturation.
- Reset mid-block discards the block and returns to the reset state.

Optional Feature:
- Macro TRANSPOSE_PINGPONG_EN.
- Defined:
  - Two storage banks with independent full flags; the write pointer and read pointer each select a bank.
  - WR_READY = write bank not full. RD_VALID = read bank full.
  - The completing write sets the write bank's full flag and toggles the write bank. The completing read clears the read bank's full flag and toggles the read bank.
  - Fill and drain overlap, giving one block per N cycles at full rate.
  - SYNC_CLR clears both full flags and both pointers.
- Undefined: single bank and the FILL/DRAIN FSM above.

Test Plan:
- N=4, reset, write rows {0,1,2,3},{10,11,12,13},{20,21,22,23},{30,31,32,33} back-to-back, RD_READY=1 -> columns {0,10,20,30},{1,11,21,31},{2,12,22,32},{3,13,23,33} on 4 consecutive cycles. RD_VALID rises the cycle after the 4th write. RD_LAST is high only on column 3. WR_READY returns 1 the cycle after column 3.
- Signed extremes: row 0 = {-1024,1023,-1,0} -> column k element 0 equals the exact 11-bit pattern: 0x400, 0x3FF, 0x7FF, 0x000.
- RD_READY low for 5 cycles at column 2 -> RD_COL and RD_COL_IDX=2 stay stable; WR_READY stays 0; WR_VALID pulses in that window store nothing.
- SYNC_CLR asserted after 2 of 4 rows, then a full new block written -> output columns contain only the new block's values; the first 2 rows are not counted.
- RST_ASYNC_N pulsed low during DRAIN at column 1 -> RD_VALID=0 immediately; the next RD_COL after a refill shows only new data; storage reads 0 before the refill.
- With TRANSPOSE_PINGPONG_EN: 3 blocks written continuously, RD_READY=1 -> WR_READY never drops. Output runs at 1 column/cycle after the first block fills, and block order is preserved.

Source files
------------

// File: rtl/transposed_buffer_reader.sv
// Row-in / column-out NxN transpose buffer between the horizontal and vertical interpolation filters.
// Define TRANSPOSE_PINGPONG_EN for two storage banks so that fill and drain overlap.
module transposed_buffer_reader #(
    parameter int N      = 8,
    parameter int DATA_W = 11
) (
    input  logic                  CLK,
    input  logic                  RST_ASYNC_N,
    input  logic                  SYNC_CLR,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    input  logic [N*DATA_W-1:0]   WR_ROW,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [N*DATA_W-1:0]   RD_COL,
    output logic [$clog2(N)-1:0]  RD_COL_IDX,
    output logic                  RD_LAST
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic [DATA_W-1:0] mem [NB][N][N];
    logic [CW-1:0]     row_cnt;
    logic [CW-1:0]     col_cnt;
    logic              wr_bank;
    logic              rd_bank;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_done;
    logic              rd_done;

    // SYNC_CLR wins over any handshake in the same cycle, so it gates both fires.
    assign wr_fire = WR_VALID & WR_READY & ~SYNC_CLR;
    assign rd_fire = RD_VALID & RD_READY & ~SYNC_CLR;
    assign wr_done = wr_fire & (row_cnt == LAST);
    assign rd_done = rd_fire & (col_cnt == LAST);

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (SYNC_CLR) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            if (wr_fire) row_cnt <= wr_done ? '0 : row_cnt + CW'(1);
            if (rd_fire) col_cnt <= rd_done ? '0 : col_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            for (int unsigned b = 0; b < NB; b++)
                for (int unsigned r = 0; r < N; r++)
                    for (int unsigned k = 0; k < N; k++)
                        mem[b][r][k] <= '0;
        end else if (wr_fire) begin
            for (int unsigned r = 0; r < N; r++)
                if (row_cnt == CW'(r))
                    for (int unsigned k = 0; k < N; k++)
                        mem[wr_bank][r][k] <= WR_ROW[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        RD_COL = '0;
        for (int unsigned r = 0; r < N; r++)
            RD_COL[r*DATA_W +: DATA_W] = mem[rd_bank][r][col_cnt];
    end

    assign RD_COL_IDX = col_cnt;
    assign RD_LAST    = RD_VALID & (col_cnt == LAST);

`ifdef TRANSPOSE_PINGPONG_EN
    logic [1:0] full;

    // Both completions in one cycle always target different banks (one is full, one is not).
    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else if (SYNC_CLR) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    assign WR_READY = ~full[wr_bank];
    assign RD_VALID = full[rd_bank];
`else
    typedef enum logic {FILL, DRAIN} state_t;
    state_t state;
    state_t state_nxt;

    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) state <= FILL;
        else              state <= state_nxt;
    end

    // Readiness is implied by the state here, so transitions test the raw valids.
    always_comb begin
        state_nxt = state;
        WR_READY  = 1'b0;
        RD_VALID  = 1'b0;
        case (state)
            FILL: begin
                WR_READY = 1'b1;
                if (WR_VALID && row_cnt == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                RD_VALID = 1'b1;
                if (RD_READY && col_cnt == LAST) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
        if (SYNC_CLR) state_nxt = FILL;
    end
`endif

endmodule
